uart_tx_buffered: RTL and testbench

//   Buffered 8N1 UART transmitter, single clock domain (clk_50m). The CPU/DataMem side pushes bytes

---
 rtl/uart_tx_buffered_pkg.sv | 11 +
 rtl/uart_tx_fifo.sv | 36 +++
 rtl/uart_tx_buffered.sv | 79 +++++++
 tb/tb_uart_tx_buffered.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: shared 8N1 frame constants, FSM states and baud divider helper
package uart_tx_buffered_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LINE = 1'b1;
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO, extra pointer MSB distinguishes full from empty
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_50m,
  input  logic             reset_b,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
    end
  end
  always_ff @(posedge clk_50m) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter with free/interrupt status
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_50m,
  input  logic       reset_b,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       overflow,
  output logic       uart_txd,
  input  logic       tx_interrupt_en,
  input  logic       tx_int_clear,
  output logic       tx_interrupt_status,
  output logic       free
);
  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV + 1);
  tx_state_t state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, fifo_dout;
  logic fifo_empty, push, pop, baud_done, int_set;
  assign push = wr_en && !full;
  assign baud_done = baud_cnt == CW'(DIV - 1);
  assign free = state == IDLE && fifo_empty;
  // Status only sets when the last queued byte finishes, never between back-to-back frames
  assign int_set = state == STOP && baud_done && fifo_empty && tx_interrupt_en;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_50m(clk_50m),
    .reset_b(reset_b),
    .push(push),
    .pop(pop),
    .din(wr_data),
    .dout(fifo_dout),
    .full(full),
    .empty(fifo_empty)
  );
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = fifo_empty ? IDLE : START;
        pop = !fifo_empty;
      end
      START: state_nxt = baud_done ? DATA : START;
      DATA: state_nxt = (baud_done && bit_cnt == 3'(DATA_BITS - 1)) ? STOP : DATA;
      STOP: begin
        state_nxt = !baud_done ? STOP : fifo_empty ? IDLE : START;
        pop = baud_done && !fifo_empty;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_50m or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      uart_txd <= IDLE_LINE;
      overflow <= 1'b0;
      tx_interrupt_status <= 1'b0;
    end else begin
      state <= state_nxt;
      baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
      bit_cnt <= state != DATA ? '0 : bit_cnt + 3'(baud_done);
      shift <= pop ? fifo_dout : (state == DATA && baud_done) ? shift >> 1 : shift;
      uart_txd <= state == START ? START_BIT : state == DATA ? shift[0] : state == STOP ? STOP_BIT : IDLE_LINE;
      overflow <= wr_en && full;
      tx_interrupt_status <= (tx_int_clear || push) ? 1'b0 : int_set ? 1'b1 : tx_interrupt_status;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed stimulus with a byte scoreboard checked by a line decoder
module tb_uart_tx_buffered;
  logic clk_50m = 1'b0;
  logic reset_b = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic tx_interrupt_en = 1'b0;
  logic tx_int_clear = 1'b0;
  logic full, overflow, uart_txd, tx_interrupt_status, free;
  logic [7:0] exp_q[$];
  logic aborted = 1'b0;
  int checks = 0;
  int failures = 0;

  uart_tx_buffered #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk_50m(clk_50m),
    .reset_b(reset_b),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .full(full),
    .overflow(overflow),
    .uart_txd(uart_txd),
    .tx_interrupt_en(tx_interrupt_en),
    .tx_int_clear(tx_int_clear),
    .tx_interrupt_status(tx_interrupt_status),
    .free(free)
  );

  always #5 clk_50m = ~clk_50m;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [7:0] b, input logic acc);
    wr_en = 1'b1;
    wr_data = b;
    tick(1);
    wr_en = 1'b0;
    wr_data = 8'($urandom);
    if (acc) exp_q.push_back(b);
    chk("overflow", {31'd0, overflow}, {31'd0, !acc});
  endtask

  // Line decoder: samples the middle of every bit after a falling start edge
  initial begin
    logic [7:0] got;
    logic [7:0] exp;
    forever begin
      @(posedge clk_50m);
      #1;
      if (reset_b === 1'b1 && uart_txd === 1'b0) begin
        tick(4);
        chk("start_mid", {31'd0, uart_txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          tick(10);
          got[i] = uart_txd;
        end
        tick(10);
        if (aborted) begin
          aborted = 1'b0;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          chk("stop_bit", {31'd0, uart_txd}, 32'd1);
          chk("frame_queued", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk("frame_byte", {24'd0, got}, {24'd0, exp});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_txd", {31'd0, uart_txd}, 32'd1);
    chk("rst_free", {31'd0, free}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_status", {31'd0, tx_interrupt_status}, 32'd0);
    reset_b = 1'b1;
    tick(2);
    // single byte, latency and end-of-frame status
    tx_interrupt_en = 1'b1;
    write(8'hA5, 1'b1);
    chk("a5_free_drop", {31'd0, free}, 32'd0);
    tick(1);
    chk("a5_txd_n1", {31'd0, uart_txd}, 32'd1);
    tick(1);
    chk("a5_txd_n2", {31'd0, uart_txd}, 32'd0);
    tick(98);
    chk("a5_free_n100", {31'd0, free}, 32'd0);
    chk("a5_status_n100", {31'd0, tx_interrupt_status}, 32'd0);
    tick(1);
    chk("a5_free_n101", {31'd0, free}, 32'd1);
    chk("a5_status_n101", {31'd0, tx_interrupt_status}, 32'd1);
    tx_int_clear = 1'b1;
    tick(1);
    tx_int_clear = 1'b0;
    chk("clear", {31'd0, tx_interrupt_status}, 32'd0);
    // three back-to-back frames
    write(8'h00, 1'b1);
    write(8'hFF, 1'b1);
    write(8'h3C, 1'b1);
    chk("b2b_full", {31'd0, full}, 32'd0);
    tick(99);
    chk("b2b_stop1", {31'd0, uart_txd}, 32'd1);
    tick(1);
    chk("b2b_start2", {31'd0, uart_txd}, 32'd0);
    tick(99);
    chk("b2b_stop2", {31'd0, uart_txd}, 32'd1);
    tick(1);
    chk("b2b_start3", {31'd0, uart_txd}, 32'd0);
    tick(98);
    chk("b2b_free_300", {31'd0, free}, 32'd0);
    tick(1);
    chk("b2b_free_301", {31'd0, free}, 32'd1);
    chk("b2b_status", {31'd0, tx_interrupt_status}, 32'd1);
    tx_int_clear = 1'b1;
    tick(1);
    tx_int_clear = 1'b0;
    // fill past depth while idle with interrupts disabled
    tx_interrupt_en = 1'b0;
    write(8'h11, 1'b1);
    write(8'h22, 1'b1);
    write(8'h33, 1'b1);
    write(8'h44, 1'b1);
    write(8'h55, 1'b1);
    chk("fill_full", {31'd0, full}, 32'd1);
    write(8'h66, 1'b0);
    chk("ovf_full", {31'd0, full}, 32'd1);
    tick(1);
    chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    tick(494);
    chk("fill_free_500", {31'd0, free}, 32'd0);
    tick(1);
    chk("fill_free_501", {31'd0, free}, 32'd1);
    chk("en0_status", {31'd0, tx_interrupt_status}, 32'd0);
    // clear coinciding with set
    tx_interrupt_en = 1'b1;
    write(8'h5A, 1'b1);
    tick(100);
    tx_int_clear = 1'b1;
    tick(1);
    tx_int_clear = 1'b0;
    chk("clr_wins", {31'd0, tx_interrupt_status}, 32'd0);
    chk("clr_free", {31'd0, free}, 32'd1);
    // en=0 does not clear a set status
    write(8'hC3, 1'b1);
    tick(101);
    chk("c3_status", {31'd0, tx_interrupt_status}, 32'd1);
    tx_interrupt_en = 1'b0;
    tick(3);
    chk("en0_keeps", {31'd0, tx_interrupt_status}, 32'd1);
    tx_int_clear = 1'b1;
    tick(1);
    tx_int_clear = 1'b0;
    tx_interrupt_en = 1'b1;
    // write on the STOP->IDLE edge
    write(8'h96, 1'b1);
    tick(100);
    write(8'h69, 1'b1);
    chk("wr_stop_status", {31'd0, tx_interrupt_status}, 32'd0);
    chk("wr_stop_free", {31'd0, free}, 32'd0);
    tick(1);
    chk("wr_stop_txd_hi", {31'd0, uart_txd}, 32'd1);
    tick(1);
    chk("wr_stop_txd_lo", {31'd0, uart_txd}, 32'd0);
    tick(98);
    chk("wr_stop_st_pre", {31'd0, tx_interrupt_status}, 32'd0);
    tick(1);
    chk("wr_stop_st_set", {31'd0, tx_interrupt_status}, 32'd1);
    tx_int_clear = 1'b1;
    tick(1);
    tx_int_clear = 1'b0;
    // reset during data bit 3
    write(8'hB7, 1'b1);
    tick(45);
    aborted = 1'b1;
    reset_b = 1'b0;
    #1;
    chk("abort_txd", {31'd0, uart_txd}, 32'd1);
    chk("abort_free", {31'd0, free}, 32'd1);
    chk("abort_full", {31'd0, full}, 32'd0);
    tick(2);
    reset_b = 1'b1;
    tick(60);
    chk("abort_idle_txd", {31'd0, uart_txd}, 32'd1);
    chk("abort_idle_free", {31'd0, free}, 32'd1);
    write(8'h4D, 1'b1);
    tick(1);
    chk("post_rst_n1", {31'd0, uart_txd}, 32'd1);
    tick(1);
    chk("post_rst_n2", {31'd0, uart_txd}, 32'd0);
    tick(100);
    chk("post_rst_free", {31'd0, free}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
